// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
//
// Multi-cycle wide adder. One 8-bit prefix-add slice is shared across an
// NBYTES-wide operand. Bytes are processed LSB first, and a registered carry
// links each byte to the next. Only one operation is in flight at a time.
// Both the request side and the result side use a valid/ready handshake.
//
// Optional feature macro: WAS_SUB_EN
//   defined   : adds the 'sub' port. With sub=1 the result is a - b - cin,
//               cin acts as a borrow-in, and cout=1 means no borrow.
//   undefined : addition only. No subtract logic is built.
//
// Latency is NBYTES cycles from accept to out_valid. With out_ready held
// high, a new operation is accepted every NBYTES+1 cycles.
// -----------------------------------------------------------------------------
module wide_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef WAS_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  busy
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // 8-bit Kogge-Stone slice: generate/propagate prefix tree, then sum bits.
  // Returns {carry_out, sum[7:0]}.
  // ---------------------------------------------------------------------------
  function automatic logic [8:0] prefix_add8(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic       c0);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] gg;
    logic [7:0] pp;
    logic [7:0] gn;
    logic [7:0] pn;
    logic [8:0] c;
    logic [7:0] s;
    g  = x & y;
    p  = x ^ y;
    gg = g;
    pp = p;
    // Three prefix levels (span 1, 2, 4) yield the group terms for bits i..0.
    for (int d = 1; d < 8; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < 8; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    c[0] = c0;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = gg[i] | (pp[i] & c0);
    end
    s = p ^ c[7:0];
    return {c[8], s};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    sum_q;
  logic            carry;
  logic            cout_q;
  logic [IDXW-1:0] idx;

  logic            accept;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [8:0]      slice;
  logic [W-1:0]    b_load;
  logic            carry_load;

  // Byte selection and the shared add slice.
  always_comb begin
    a_byte = op_a[8*idx +: 8];
    b_byte = op_b[8*idx +: 8];
    slice  = prefix_add8(a_byte, b_byte, carry);
  end

  // Operand B and initial carry as loaded on accept. In subtract mode B is
  // inverted and cin is inverted, which gives a + ~b + ~cin = a - b - cin.
`ifdef WAS_SUB_EN
  always_comb begin
    b_load     = sub ? ~b   : b;
    carry_load = sub ? ~cin : cin;
  end
`else
  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples its pre-edge value and process order does not matter.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. in_ready follows out_ready in DONE so
  // a result can be retired and a new request taken on the same edge.
  always_comb begin
    // NOTE: every output of this block gets a default first. A signal left
    // unassigned on any path would infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // Operand capture on accept, then one byte per cycle while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset along with the visible state.
    // They are ordinary flops rather than a memory, so the reset costs
    // nothing and keeps X out of the slice after power-up.
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= b_load;
      carry  <= carry_load;
      sum_q  <= '0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else if (state_q == RUN) begin
      sum_q[8*idx +: 8] <= slice[7:0];
      carry             <= slice[8];
      if (idx == LAST_IDX) begin
        cout_q <= slice[8];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq
//
// Directed bench for wide_add_seq. It uses an NBYTES=4 instance for most
// checks and an NBYTES=1 instance for the single-byte case. Expected results
// come from a reference arithmetic model and go into a scoreboard queue when
// an operation is accepted. They are popped when out_valid is seen.
// Define WAS_SUB_EN to build and exercise the subtract path as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wide_add_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        cin1;
  logic        sub1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  sum1;
  logic        cout1;
  logic        busy1;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_add_seq #(.NBYTES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef WAS_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  wide_add_seq #(.NBYTES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef WAS_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a+b+cin, or a-b-cin with cout = no borrow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    exp_t       e;
    logic [32:0] t;
    if (s) begin
      e.sum  = x - y - {31'd0, c};
      e.cout = ({1'b0, x} >= ({1'b0, y} + {32'd0, c}));
    end else begin
      t      = {1'b0, x} + {1'b0, y} + {32'd0, c};
      e.sum  = t[31:0];
      e.cout = t[32];
    end
    return e;
  endfunction

  // Wait (bounded) for in_ready, present the operation, and push the expected result.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic c, input logic s);
    int waited;
    waited = 0;
    @(negedge clk);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check("send_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    sb.push_back(model(x, y, c, s));
    #1 in_valid = 1'b0;
  endtask

  // Count edges to out_valid, check latency and data, hold out_ready low for
  // 'hold' cycles, then retire the result.
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    logic [31:0] held;
    lat = 0;
    while (lat <= 20) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},  64'(sum),  64'(e.sum));
      check({tag, "_cout"}, 64'(cout), 64'(e.cout));
    end
    held = sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_sum"},   64'(sum),       64'(held));
      check({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1 check({tag, "_ready_follow"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_retired"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] bb_a [3];
  logic [31:0] bb_b [3];
  int          acc_cyc [3];
  int          n_acc;
  int          n_res;
  int          pend;
  exp_t        e1;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;
    bb_a = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000};
    bb_b = '{32'h0000_0002, 32'h1111_1111, 32'h8000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    rst_n = 1'b1;

    // Full carry ripple: FFFFFFFF + 1
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("run_busy",     64'(busy),      64'd1);
    check("run_in_ready", 64'(in_ready),  64'd0);
    check("run_valid",    64'(out_valid), 64'd0);
    collect("ripple", 4, 0);

    // Held result with out_ready low for 5 cycles
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    collect("hold", 4, 5);

    // A few more operand patterns
    send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0);
    collect("mid_carry", 4, 0);
    for (int i = 0; i < 3; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      collect("rand", 4, 1);
    end

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    n_acc = 0; n_res = 0; pend = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_valid) begin
        n_res++;
        if (sb.size() == 0) begin
          check("b2b_sb_empty", 64'(sb.size()), 64'd1);
        end else begin
          e1 = sb.pop_front();
          check("b2b_sum",  64'(sum),  64'(e1.sum));
          check("b2b_cout", 64'(cout), 64'(e1.cout));
        end
      end
      if (pend != 0) begin
        n_acc++;
        pend = 0;
      end
      if (n_acc < 3) begin
        a = bb_a[n_acc]; b = bb_b[n_acc]; cin = 1'b0; in_valid = 1'b1;
        #1;
        if (in_ready) begin
          sb.push_back(model(bb_a[n_acc], bb_b[n_acc], 1'b0, 1'b0));
          acc_cyc[n_acc] = cyc;
          pend = 1;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd3);
    check("b2b_results", 64'(n_res), 64'd3);
    check("b2b_gap01",   64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
    check("b2b_gap12",   64'(acc_cyc[2] - acc_cyc[1]), 64'd5);

    // Reset in the middle of RUN
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_sum",       64'(sum),       64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_busy",      64'(busy),      64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    collect("post_rst", 4, 0);

`ifdef WAS_SUB_EN
    // Subtract path
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    collect("sub_borrow", 4, 0);
    send(32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1);
    collect("sub_noborrow", 4, 0);
    send(32'h0000_0020, 32'h0000_0010, 1'b1, 1'b1);
    collect("sub_bin", 4, 0);
`endif

    // NBYTES=1 instance: 0x80 + 0x80 + 1
    @(negedge clk);
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1; in_valid1 = 1'b1;
    #1 check("b1_in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    check("b1_run_valid", 64'(out_valid1), 64'd0);
    @(posedge clk);
    #1;
    check("b1_valid", 64'(out_valid1), 64'd1);
    check("b1_sum",   64'(sum1),       64'h01);
    check("b1_cout",  64'(cout1),      64'd1);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    check("b1_retired", 64'(out_valid1), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
